// File: rtl/regfile_wr_arbiter_if.sv
// Writeback bus between the four requesters, the arbiter and the register-file write port.
// The master side drives requests; the slave side is the arbiter.
interface regfile_wr_arbiter_if #(
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned ADDR_BITS = 5,
    parameter int unsigned CNT_BITS  = 16
);
    logic                     stall;
    logic [3:0]               req_valid;
    logic [3:0]               req_ready;
    logic [4*ADDR_BITS-1:0]   req_addr;
    logic [4*DATA_BITS-1:0]   req_data;
    logic [1:0]               grant_sel;
    logic                     wr_en;
    logic [ADDR_BITS-1:0]     wr_addr;
    logic [DATA_BITS-1:0]     wr_data;
    logic [CNT_BITS-1:0]      conflict_count;

    modport master (
        output stall, req_valid, req_addr, req_data,
        input  req_ready, grant_sel, wr_en, wr_addr, wr_data, conflict_count
    );

    modport slave (
        input  stall, req_valid, req_addr, req_data,
        output req_ready, grant_sel, wr_en, wr_addr, wr_data, conflict_count
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among four writeback units,
// with a registered write stage and a saturating contention counter.
module regfile_wr_arbiter #(
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned ADDR_BITS = 5,
    parameter int unsigned CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int unsigned NREQ = 4;

    logic [1:0]          rr_ptr;
    logic [2*NREQ-1:0]   valid_dbl_c;
    logic [NREQ-1:0]     valid_rot_c;
    logic [1:0]          offset_c;
    logic [1:0]          grant_idx_c;
    logic                grant_vld_c;
    logic                multi_req_c;
    logic [ADDR_BITS-1:0] grant_addr_c;
    logic [DATA_BITS-1:0] grant_data_c;

    // Rotate the request vector so the current priority holder sits at bit 0.
    always_comb begin
        valid_dbl_c = {bus.req_valid, bus.req_valid};
        valid_rot_c = NREQ'(valid_dbl_c >> rr_ptr);
        offset_c    = 2'd0;
        if (valid_rot_c[0])      offset_c = 2'd0;
        else if (valid_rot_c[1]) offset_c = 2'd1;
        else if (valid_rot_c[2]) offset_c = 2'd2;
        else if (valid_rot_c[3]) offset_c = 2'd3;
        grant_idx_c  = rr_ptr + offset_c;
        grant_vld_c  = !bus.stall && (|bus.req_valid);
        multi_req_c  = ($countones(bus.req_valid) >= 2);
        grant_addr_c = bus.req_addr[grant_idx_c*ADDR_BITS +: ADDR_BITS];
        grant_data_c = bus.req_data[grant_idx_c*DATA_BITS +: DATA_BITS];
    end

    // Ready is combinational so a grant and its transfer happen in the same cycle.
    assign bus.req_ready = (grant_vld_c && !reset) ? (NREQ'(1) << grant_idx_c) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr             <= 2'd0;
            bus.grant_sel      <= 2'd0;
            bus.wr_en          <= 1'b0;
            bus.wr_addr        <= '0;
            bus.wr_data        <= '0;
            bus.conflict_count <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            if (grant_vld_c) begin
                rr_ptr        <= grant_idx_c + 2'd1;
                bus.grant_sel <= grant_idx_c;
                bus.wr_addr   <= grant_addr_c;
                bus.wr_data   <= grant_data_c;
                // Register 0 is hardwired zero: accept the transfer but suppress the strobe.
                bus.wr_en     <= (grant_addr_c != '0);
            end
            if (multi_req_c && (bus.conflict_count != '1)) begin
                bus.conflict_count <= bus.conflict_count + CNT_BITS'(1);
            end
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized and directed bench for regfile_wr_arbiter against a behavioural reference model.
module tb_regfile_wr_arbiter;
    localparam int unsigned DB = 32;
    localparam int unsigned AB = 5;
    localparam int unsigned CB = 16;
    localparam int unsigned CNT_MAX = 65535;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.DATA_BITS(DB), .ADDR_BITS(AB), .CNT_BITS(CB)) bus ();
    regfile_wr_arbiter_if #(.DATA_BITS(DB), .ADDR_BITS(AB), .CNT_BITS(4))  sbus ();

    regfile_wr_arbiter #(.DATA_BITS(DB), .ADDR_BITS(AB), .CNT_BITS(CB)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );
    regfile_wr_arbiter #(.DATA_BITS(DB), .ADDR_BITS(AB), .CNT_BITS(4)) dut_sat (
        .clk(clk), .reset(reset), .bus(sbus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int             m_rr;
    int             m_cnt;
    logic [1:0]     m_sel;
    logic           m_en;
    logic [AB-1:0]  m_addr;
    logic [DB-1:0]  m_data;
    int             last_g;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int rr);
        for (int k = 0; k < 4; k++) begin
            if (v[(rr + k) % 4]) return (rr + k) % 4;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [AB-1:0] a, input logic [DB-1:0] d);
        bus.req_addr[i*AB +: AB] = a;
        bus.req_data[i*DB +: DB] = d;
    endtask

    task automatic model_reset();
        m_rr = 0; m_cnt = 0; m_sel = 2'd0; m_en = 1'b0; m_addr = '0; m_data = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_wr_en"}, 64'(bus.wr_en), 64'(m_en));
        check({tag, "_sel"},   64'(bus.grant_sel), 64'(m_sel));
        check({tag, "_addr"},  64'(bus.wr_addr), 64'(m_addr));
        check({tag, "_data"},  64'(bus.wr_data), 64'(m_data));
        check({tag, "_cnt"},   64'(bus.conflict_count), 64'(m_cnt));
    endtask

    // One clock: inputs were driven after the previous falling edge.
    task automatic step(input string tag);
        int g;
        logic [3:0] exp_ready;
        logic [AB-1:0] ga;
        logic [DB-1:0] gd;
        #1;
        g = bus.stall ? -1 : pick(bus.req_valid, m_rr);
        exp_ready = (g < 0) ? 4'd0 : 4'(1 << g);
        check({tag, "_ready"}, 64'(bus.req_ready), 64'(exp_ready));
        if (g >= 0) begin
            ga = bus.req_addr[g*AB +: AB];
            gd = bus.req_data[g*DB +: DB];
        end else begin
            ga = '0; gd = '0;
        end
        if ($countones(bus.req_valid) >= 2 && m_cnt < int'(CNT_MAX)) m_cnt++;
        @(posedge clk);
        if (g >= 0) begin
            m_rr = (g + 1) % 4; m_sel = 2'(g); m_addr = ga; m_data = gd; m_en = (ga != '0);
        end else begin
            m_en = 1'b0;
        end
        last_g = g;
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.stall = 1'b0; bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [3:0]    pend;
    logic [AB-1:0] ra;
    logic [DB-1:0] rd;

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0; bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
        sbus.stall = 1'b0; sbus.req_valid = '0; sbus.req_addr = '0; sbus.req_data = '0;
        model_reset();
        last_g = -1;
        #12;
        check_outputs("reset");
        check("reset_ready", 64'(bus.req_ready), 64'd0);

        // Single write
        do_reset();
        bus.req_valid = 4'b0010;
        set_req(1, 5'd5, 32'hDEADBEEF);
        step("t1");
        check("t1_en",   64'(bus.wr_en), 64'd1);
        check("t1_addr", 64'(bus.wr_addr), 64'd5);
        check("t1_data", 64'(bus.wr_data), 64'hDEADBEEF);
        check("t1_sel",  64'(bus.grant_sel), 64'd1);
        check("t1_cnt",  64'(bus.conflict_count), 64'd0);

        // Full contention
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, AB'(i + 1), DB'(32'h1000 + i));
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step("t2");
            check("t2_grant", 64'(bus.grant_sel), 64'(k % 4));
            check("t2_en", 64'(bus.wr_en), 64'd1);
        end
        check("t2_cnt", 64'(bus.conflict_count), 64'd8);

        // Zero-register write, then 3 and 0 alternate
        do_reset();
        bus.req_valid = 4'b0100;
        set_req(2, 5'd0, 32'h2222);
        step("t3");
        check("t3_en0", 64'(bus.wr_en), 64'd0);
        check("t3_sel", 64'(bus.grant_sel), 64'd2);
        check("t3_addr", 64'(bus.wr_addr), 64'd0);
        bus.req_valid = 4'b1001;
        set_req(0, 5'd7, 32'h7777);
        set_req(3, 5'd9, 32'h9999);
        for (int k = 0; k < 4; k++) begin
            step("t3b");
            check("t3_alt", 64'(bus.grant_sel), (k % 2 == 0) ? 64'd3 : 64'd0);
        end

        // Stall with rr_ptr = 2
        do_reset();
        bus.req_valid = 4'b0010;
        set_req(1, 5'd3, 32'h3333);
        step("t4a");
        for (int i = 0; i < 4; i++) set_req(i, AB'(i + 10), DB'(32'h4000 + i));
        bus.req_valid = 4'b1111;
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step("t4s");
            check("t4_stall_en", 64'(bus.wr_en), 64'd0);
        end
        check("t4_cnt", 64'(bus.conflict_count), 64'd3);
        bus.stall = 1'b0;
        step("t4r");
        check("t4_first", 64'(bus.grant_sel), 64'd2);

        // Reset between clock edges during a burst
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, AB'(i + 1), DB'(32'h5000 + i));
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) step("t5a");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs("t5rst");
        check("t5_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        step("t5b");
        check("t5_first", 64'(bus.grant_sel), 64'd0);

        // Randomized traffic obeying the hold-until-ready handshake
        do_reset();
        pend = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    ra = AB'($urandom_range(0, 31));
                    rd = $urandom;
                    set_req(i, ra, rd);
                end
            end
            bus.req_valid = pend;
            bus.stall = ($urandom_range(0, 4) == 0);
            step("rnd");
            if (last_g >= 0) pend[last_g] = 1'b0;
        end
        bus.req_valid = '0;
        bus.stall = 1'b0;

        // Saturation on the 4-bit counter instance
        do_reset();
        sbus.req_valid = 4'b0011;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            check("t6_cnt", 64'(sbus.conflict_count), 64'((k < 15) ? k : 15));
        end
        sbus.req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
